// File: rtl/debounce_pkg.sv
// Shared types and sizing helpers for the switch debouncer.
package debounce_pkg;

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        PEND_HI   = 2'd1,
        STABLE_HI = 2'd2,
        PEND_LO   = 2'd3
    } db_state_e;

    // Minimum counter width able to hold the value 'ticks' (at least 1 bit).
    function automatic int unsigned cnt_width(input int unsigned ticks);
        int unsigned w;
        w = $clog2(ticks + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/input_synchronizer.sv
// Multi-flop synchronizer for an asynchronous single-bit input; resets to 0.
module input_synchronizer #(
    parameter int unsigned DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[DEPTH-2:0], d};
        end
    end

    assign q = chain[DEPTH-1];

endmodule

// File: rtl/switch_debouncer.sv
// Tick-sampled switch debouncer with optional edge pulses.
// Macro SWITCH_DEBOUNCER_EDGE_EN enables rise_pulse/fall_pulse; otherwise both are tied to 0.
module switch_debouncer
    import debounce_pkg::*;
#(
    parameter int unsigned STABLE_TICKS = 4,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic sw_raw,
    output logic sw_db,
    output logic rise_pulse,
    output logic fall_pulse
);

    localparam int unsigned CW       = cnt_width(STABLE_TICKS);
    localparam logic [CW-1:0] LAST_CNT = CW'(STABLE_TICKS - 1);
    localparam bit ONE_TICK          = (STABLE_TICKS == 1);

    logic            sw_sync;
    db_state_e       state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            db_d;

    input_synchronizer #(
        .DEPTH (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (sw_raw),
        .q     (sw_sync)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= STABLE_LO;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Candidate level must agree on STABLE_TICKS consecutive ticks before acceptance.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (tick) begin
            case (state_q)
                STABLE_LO: begin
                    if (sw_sync) begin
                        if (ONE_TICK) begin
                            state_d = STABLE_HI;
                        end else begin
                            state_d = PEND_HI;
                            cnt_d   = CW'(1);
                        end
                    end
                end
                PEND_HI: begin
                    if (!sw_sync) begin
                        state_d = STABLE_LO;
                        cnt_d   = '0;
                    end else if (cnt_q == LAST_CNT) begin
                        state_d = STABLE_HI;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                STABLE_HI: begin
                    if (!sw_sync) begin
                        if (ONE_TICK) begin
                            state_d = STABLE_LO;
                        end else begin
                            state_d = PEND_LO;
                            cnt_d   = CW'(1);
                        end
                    end
                end
                PEND_LO: begin
                    if (sw_sync) begin
                        state_d = STABLE_HI;
                        cnt_d   = '0;
                    end else if (cnt_q == LAST_CNT) begin
                        state_d = STABLE_LO;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d = STABLE_LO;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign db_d = (state_d == STABLE_HI) || (state_d == PEND_LO);

    // Level register updates on the same edge that enters the new stable state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_db <= 1'b0;
        end else begin
            sw_db <= db_d;
        end
    end

`ifdef SWITCH_DEBOUNCER_EDGE_EN
    logic rise_q, fall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= db_d & ~sw_db;
            fall_q <= ~db_d & sw_db;
        end
    end

    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
`else
    assign rise_pulse = 1'b0;
    assign fall_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_switch_debouncer.sv
// Scoreboard bench for switch_debouncer: a tick-level reference model pushes expected
// outputs per tick; a negedge monitor pops and compares, and checks idle cycles in between.
module tb_switch_debouncer;

`ifdef SWITCH_DEBOUNCER_EDGE_EN
    localparam bit EDGE_EN = 1'b1;
`else
    localparam bit EDGE_EN = 1'b0;
`endif
    localparam int unsigned ST  = 4;
    localparam int unsigned GAP = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, tick, sw_raw, sw_db, rise_pulse, fall_pulse;
    logic sw_raw1, sw_db1, rise1, fall1;

    switch_debouncer #(.STABLE_TICKS(ST), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .sw_raw(sw_raw),
        .sw_db(sw_db), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse)
    );

    switch_debouncer #(.STABLE_TICKS(1), .SYNC_STAGES(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .tick(1'b1), .sw_raw(sw_raw1),
        .sw_db(sw_db1), .rise_pulse(rise1), .fall_pulse(fall1)
    );

    typedef struct packed {
        logic db;
        logic rise;
        logic fall;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   passed = 0;
    bit   mon_en = 1'b0;
    logic tick_at_edge = 1'b0;
    logic cur_db = 1'b0;
    logic m_db;
    int   m_run;

    always @(posedge clk) tick_at_edge <= tick;

    // Monitor: tick edges pop the scoreboard; other cycles must hold level with no pulses.
    always @(negedge clk) begin
        if (mon_en) begin
            if (tick_at_edge) begin
                checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL sb_underflow: tick result with empty scoreboard at %0t", $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    if ({sw_db, rise_pulse, fall_pulse} !== mon_e)
                        $display("FAIL tick_out at %0t: got db/rise/fall=%b, want %b",
                                 $time, {sw_db, rise_pulse, fall_pulse}, mon_e);
                    else passed++;
                    cur_db = mon_e.db;
                end
            end else begin
                checks++;
                if ({sw_db, rise_pulse, fall_pulse} !== {cur_db, 2'b00})
                    $display("FAIL idle_out at %0t: got db/rise/fall=%b, want %b",
                             $time, {sw_db, rise_pulse, fall_pulse}, {cur_db, 2'b00});
                else passed++;
            end
        end
    end

    task automatic model_reset();
        m_db   = 1'b0;
        m_run  = 0;
        cur_db = 1'b0;
        exp_q.delete();
    endtask

    // Reference: flip the accepted level after ST consecutive disagreeing samples.
    task automatic model_sample(input logic s);
        exp_t e;
        e.db = m_db; e.rise = 1'b0; e.fall = 1'b0;
        if (s !== m_db) begin
            m_run++;
            if (m_run == ST) begin
                m_db   = s;
                m_run  = 0;
                e.db   = s;
                e.rise = s & EDGE_EN;
                e.fall = ~s & EDGE_EN;
            end
        end else begin
            m_run = 0;
        end
        exp_q.push_back(e);
    endtask

    // Each tick follows GAP-1 idle clocks so sw_raw has settled through the synchronizer.
    task automatic run_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            repeat (GAP - 1) @(posedge clk);
            #1 tick = 1'b1;
            model_sample(sw_raw);
            @(posedge clk);
            #1 tick = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; tick = 1'b0; sw_raw = 1'b0; sw_raw1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({sw_db, rise_pulse, fall_pulse, sw_db1, rise1, fall1} !== 6'b0)
            $display("FAIL reset_outs: got %b, want 000000",
                     {sw_db, rise_pulse, fall_pulse, sw_db1, rise1, fall1});
        else passed++;
        rst_n = 1'b1;
        model_reset();
        mon_en = 1'b1;
    endtask

    task automatic test_clean_step();
        sw_raw = 1'b1;
        run_ticks(6);
        sw_raw = 1'b0;
        run_ticks(6);
    endtask

    task automatic test_bounce();
        sw_raw = 1'b1; run_ticks(2);
        sw_raw = 1'b0; run_ticks(1);
        sw_raw = 1'b1; run_ticks(5);
        sw_raw = 1'b0; run_ticks(3);
        sw_raw = 1'b1; run_ticks(1);
        sw_raw = 1'b0; run_ticks(5);
    endtask

    task automatic test_glitch();
        repeat (3) @(posedge clk);
        #1 sw_raw = 1'b1;
        @(posedge clk);
        #1 sw_raw = 1'b0;
        run_ticks(3);
        sw_raw = 1'b1;
        run_ticks(5);
        repeat (3) @(posedge clk);
        #1 sw_raw = 1'b0;
        @(posedge clk);
        #1 sw_raw = 1'b1;
        run_ticks(3);
    endtask

    task automatic test_reset_mid_pending();
        sw_raw = 1'b0;
        run_ticks(5);
        sw_raw = 1'b1;
        run_ticks(3);
        @(negedge clk);
        #1 mon_en = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({sw_db, rise_pulse, fall_pulse} !== 3'b000)
            $display("FAIL rst_pend_async: got %b, want 000", {sw_db, rise_pulse, fall_pulse});
        else passed++;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        mon_en = 1'b1;
        run_ticks(5);
        @(negedge clk);
        #1 mon_en = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({sw_db, rise_pulse, fall_pulse} !== 3'b000)
            $display("FAIL rst_high_async: got %b, want 000", {sw_db, rise_pulse, fall_pulse});
        else passed++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({sw_db, rise_pulse, fall_pulse} !== 3'b000)
                $display("FAIL rst_held: got %b, want 000", {sw_db, rise_pulse, fall_pulse});
            else passed++;
        end
        sw_raw = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        mon_en = 1'b1;
        run_ticks(2);
    endtask

    task automatic test_one_tick();
        logic v;
        for (int k = 0; k < 4; k++) begin
            v = (k % 2 == 0);
            @(posedge clk);
            #1 sw_raw1 = v;
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                checks++;
                if ({sw_db1, rise1, fall1} !==
                    {((i >= 3) ? v : ~v), (EDGE_EN && i == 3 && v), (EDGE_EN && i == 3 && !v)})
                    $display("FAIL one_tick k=%0d i=%0d: got %b, want %b", k, i,
                             {sw_db1, rise1, fall1},
                             {((i >= 3) ? v : ~v), (EDGE_EN && i == 3 && v), (EDGE_EN && i == 3 && !v)});
                else passed++;
            end
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_clean_step();
        test_bounce();
        test_glitch();
        test_reset_mid_pending();
        test_one_tick();
        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0)
            $display("FAIL sb_drain: got %0d entries left, want 0", exp_q.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
